// File: rtl/bram_stage_sequencer_pkg.sv
// Shared types for the BRAM stage sequencer: FSM state encoding and stage-count limits.
package seq_pkg;

    localparam int unsigned MAX_STAGES = 8;
    localparam int unsigned IDX_W      = 3;

    // Encodings are visible on state_out, so they are pinned explicitly.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLaunch  = 3'd1,
        StRun     = 3'd2,
        StAdvance = 3'd3,
        StFinish  = 3'd4,
        StError   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/bram_stage_sequencer_if.sv
// Shared BRAM port owned by one sequenced stage at a time.
interface bram_stage_sequencer_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 3
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;

    modport master (output addr, output wdata, output we);
    modport slave  (input addr, input wdata, input we);
endinterface

// File: rtl/bram_stage_sequencer_next_enabled_idx.sv
// Priority search: lowest enabled stage index at or above from_i.
module next_enabled_idx
    import seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3
) (
    input  logic [NUM_STAGES-1:0] en_i,
    input  logic [IDX_W:0]        from_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  none_left_o
);

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        idx_o       = '0;
        none_left_o = 1'b1;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (en_i[i] && (i >= int'(from_i))) begin
                idx_o       = IDX_W'(i);
                none_left_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bram_stage_sequencer.sv
// Runs enabled stages in index order, muxing the single BRAM port to the active one.
// Optional per-stage watchdog enabled by defining STAGE_WATCHDOG_EN.
module bram_stage_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned ADDR_W          = 19,
    parameter int unsigned DATA_W          = 3,
    parameter int unsigned LAST_STAGE_HOLD = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 2 ** 24
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         go_i,
    input  logic                         abort_i,
    input  logic [NUM_STAGES-1:0]        stage_en_i,
    output logic [NUM_STAGES-1:0]        stage_start_o,
    input  logic [NUM_STAGES-1:0]        stage_done_i,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr_i,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata_i,
    input  logic [NUM_STAGES-1:0]        stage_we_i,
    bram_stage_sequencer_if.master       bram_o,
    output logic [IDX_W-1:0]             active_stage_o,
    output logic                         busy_o,
    output logic                         seq_done_o,
    output logic                         error_o,
    output logic [2:0]                   state_out_o
);

    if (NUM_STAGES < 2 || NUM_STAGES > MAX_STAGES) begin : g_bad_num_stages
        $error("NUM_STAGES must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [2:0]        state_out_q;

    logic [IDX_W:0]    search_from;
    logic [IDX_W-1:0]  next_idx;
    logic              none_left;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_done;

    // From IDLE/ERROR search from stage 0, otherwise from the stage after the owner.
    assign search_from = (state_q == StIdle || state_q == StError) ? '0
                                                                   : {1'b0, active_q} + 1'b1;

    next_enabled_idx #(
        .NUM_STAGES (NUM_STAGES)
    ) u_next_idx (
        .en_i        (stage_en_i),
        .from_i      (search_from),
        .idx_o       (next_idx),
        .none_left_o (none_left)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_done  = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (active_q == IDX_W'(i)) begin
                sel_addr  = stage_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = stage_wdata_i[i*DATA_W +: DATA_W];
                sel_we    = stage_we_i[i];
                sel_done  = stage_done_i[i];
            end
        end
    end

`ifdef STAGE_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;
    logic        error_q, error_d;
    logic        wd_hit;
    logic        wd_exempt;

    assign wd_hit    = (wd_q == 32'(TIMEOUT_CYCLES - 1));
    assign wd_exempt = (LAST_STAGE_HOLD != 0) && none_left;

    always_comb begin
        wd_d = wd_q;
        if (state_q == StLaunch) begin
            wd_d = '0;
        end else if (state_q == StRun) begin
            wd_d = wd_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
`ifdef STAGE_WATCHDOG_EN
        error_d  = error_q;
`endif
        unique case (state_q)
            StIdle, StError: begin
                if (go_i) begin
`ifdef STAGE_WATCHDOG_EN
                    error_d = 1'b0;
`endif
                    if (none_left) begin
                        state_d = StFinish;
                    end else begin
                        active_d = next_idx;
                        state_d  = StLaunch;
                    end
                end
            end
            StLaunch: state_d = StRun;
            StRun: begin
                if (sel_done && !none_left) begin
                    state_d = StAdvance;
                end else if (sel_done && LAST_STAGE_HOLD == 0) begin
                    state_d = StFinish;
`ifdef STAGE_WATCHDOG_EN
                end else if (wd_hit && !wd_exempt) begin
                    state_d = StError;
                    error_d = 1'b1;
`endif
                end
            end
            StAdvance: begin
                // Mask may have changed since RUN; finish cleanly if nothing is left.
                if (none_left) begin
                    state_d = StFinish;
                end else begin
                    active_d = next_idx;
                    state_d  = StLaunch;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (abort_i) begin
            state_d  = StIdle;
            active_d = active_q;
`ifdef STAGE_WATCHDOG_EN
            error_d  = error_q;
`endif
        end
    end

    // Writes only pass through while ownership is stable across the edge.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        if (state_q == StRun) begin
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            we_d    = (state_d == StRun) ? sel_we : 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            active_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            state_out_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            state_out_q <= state_q;
        end
    end

    always_comb begin
        stage_start_o = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_start_o[i] = (state_q == StLaunch) && !abort_i && (active_q == IDX_W'(i));
        end
    end

    assign bram_o.addr    = addr_q;
    assign bram_o.wdata   = wdata_q;
    assign bram_o.we      = we_q;
    assign active_stage_o = active_q;
    assign busy_o         = (state_q != StIdle);
    assign seq_done_o     = (state_q == StFinish);
    assign state_out_o    = state_out_q;

endmodule

// File: tb/tb_bram_stage_sequencer.sv
// Directed plus randomized bench for bram_stage_sequencer (hold and no-hold builds side by side).
module tb_bram_stage_sequencer;

    localparam int NS = 3;
    localparam int AW = 19;
    localparam int DW = 3;
    localparam int TO = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_FIN    = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          go, abort;
    logic [NS-1:0] en, done, we_in;
    logic [NS*AW-1:0] addr_in;
    logic [NS*DW-1:0] wdata_in;

    logic [NS-1:0] h_start, s_start, o_start;
    logic [2:0]    h_act, s_act, o_act, h_st, s_st, o_st;
    logic          h_busy, s_busy, o_busy, h_sd, s_sd, o_sd, h_err, s_err, o_err, o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wd;
    logic          sel;

    int checks = 0;
    int errors = 0;

    bram_stage_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) h_bram ();
    bram_stage_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) s_bram ();

    bram_stage_sequencer #(
        .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .LAST_STAGE_HOLD(1), .TIMEOUT_CYCLES(TO)
    ) u_dut_hold (
        .clk_i(clk), .rst_i(rst), .go_i(go), .abort_i(abort), .stage_en_i(en),
        .stage_start_o(h_start), .stage_done_i(done), .stage_addr_i(addr_in),
        .stage_wdata_i(wdata_in), .stage_we_i(we_in), .bram_o(h_bram),
        .active_stage_o(h_act), .busy_o(h_busy), .seq_done_o(h_sd), .error_o(h_err),
        .state_out_o(h_st)
    );

    bram_stage_sequencer #(
        .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .LAST_STAGE_HOLD(0), .TIMEOUT_CYCLES(TO)
    ) u_dut_seq (
        .clk_i(clk), .rst_i(rst), .go_i(go), .abort_i(abort), .stage_en_i(en),
        .stage_start_o(s_start), .stage_done_i(done), .stage_addr_i(addr_in),
        .stage_wdata_i(wdata_in), .stage_we_i(we_in), .bram_o(s_bram),
        .active_stage_o(s_act), .busy_o(s_busy), .seq_done_o(s_sd), .error_o(s_err),
        .state_out_o(s_st)
    );

    // sel = 0 observes the hold build, 1 the sequence-completing build.
    always_comb begin
        o_start = sel ? s_start : h_start;
        o_act   = sel ? s_act : h_act;
        o_st    = sel ? s_st : h_st;
        o_busy  = sel ? s_busy : h_busy;
        o_sd    = sel ? s_sd : h_sd;
        o_err   = sel ? s_err : h_err;
        o_we    = sel ? s_bram.we : h_bram.we;
        o_addr  = sel ? s_bram.addr : h_bram.addr;
        o_wd    = sel ? s_bram.wdata : h_bram.wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        go = 1'b0; abort = 1'b0; done = '0; we_in = '0; addr_in = '0; wdata_in = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic rand_stage_inputs();
        for (int i = 0; i < NS; i++) begin
            addr_in[i*AW +: AW]  = AW'($urandom);
            wdata_in[i*DW +: DW] = DW'($urandom);
        end
        we_in = NS'($urandom);
    endtask

    // Expected behaviour: enabled stages run in ascending order, one start pulse each.
    task automatic run_seq(input logic [NS-1:0] mask, input bit hold);
        int order[$];
        logic [NS*AW-1:0] p_addr;
        logic [NS*DW-1:0] p_wd;
        logic [NS-1:0]    p_we;
        sel = !hold;
        for (int i = 0; i < NS; i++) if (mask[i]) order.push_back(i);
        en = mask;
        go = 1'b1;
        step();
        go = 1'b0;
        if (order.size() == 0) begin
            check("empty_seq_done", 32'(o_sd), 32'd1);
            check("empty_start", 32'(o_start), 32'd0);
            step();
            check("empty_busy_low", 32'(o_busy), 32'd0);
            check("empty_seq_done_low", 32'(o_sd), 32'd0);
            return;
        end
        for (int k = 0; k < order.size(); k++) begin
            int a;
            int lat;
            a   = order[k];
            lat = int'($urandom_range(1, 8));
            check("launch_start", 32'(o_start), 32'(1 << a));
            check("launch_act", 32'(o_act), 32'(a));
            check("launch_busy", 32'(o_busy), 32'd1);
            done = NS'(1 << a);  // overlaps the start pulse, must be ignored
            step();
            done = '0;
            check("run_first_we", 32'(o_we), 32'd0);
            check("run_start_low", 32'(o_start), 32'd0);
            check("run_state_out", 32'(o_st), 32'(S_LAUNCH));
            for (int c = 0; c < lat; c++) begin
                rand_stage_inputs();
                done = NS'($urandom) & ~NS'(1 << a);
                if (c == lat - 1) done[a] = 1'b1;
                p_addr = addr_in;
                p_wd   = wdata_in;
                p_we   = we_in;
                step();
                done = '0;
                if (c < lat - 1) begin
                    check("run_we", 32'(o_we), 32'(p_we[a]));
                    check("run_addr", 32'(o_addr), 32'(p_addr[a*AW +: AW]));
                    check("run_wdata", 32'(o_wd), 32'(p_wd[a*DW +: DW]));
                end
            end
            if (k < order.size() - 1) begin
                check("adv_we", 32'(o_we), 32'd0);
                check("adv_start", 32'(o_start), 32'd0);
                check("adv_seq_done", 32'(o_sd), 32'd0);
                step();
            end else if (!hold) begin
                check("fin_seq_done", 32'(o_sd), 32'd1);
                check("fin_we", 32'(o_we), 32'd0);
                check("fin_busy", 32'(o_busy), 32'd1);
                step();
                check("idle_busy", 32'(o_busy), 32'd0);
                check("idle_seq_done", 32'(o_sd), 32'd0);
                check("idle_state_out", 32'(o_st), 32'(S_FIN));
            end else begin
                for (int c = 0; c < 4; c++) begin
                    done = NS'(1 << a);
                    step();
                    check("hold_busy", 32'(o_busy), 32'd1);
                    check("hold_seq_done", 32'(o_sd), 32'd0);
                    check("hold_act", 32'(o_act), 32'(a));
                    check("hold_state_out", 32'(o_st), 32'(S_RUN));
                end
                done = '0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout bench exceeded its time limit");
        $fatal(1);
    end

    initial begin
        go = 1'b0; abort = 1'b0; en = '0; done = '0;
        we_in = '0; addr_in = '0; wdata_in = '0; sel = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(h_busy), 32'd0);
        check("rst_start", 32'(h_start), 32'd0);
        check("rst_we", 32'(h_bram.we), 32'd0);
        check("rst_act", 32'(h_act), 32'd0);
        check("rst_state_out", 32'(h_st), 32'(S_IDLE));
        check("rst_err", 32'(h_err), 32'd0);
        check("rst_seq_done", 32'(s_sd), 32'd0);
        rst = 1'b0;
        step();

        do_reset(); run_seq(3'b111, 1'b1);
        do_reset(); run_seq(3'b101, 1'b0);
        do_reset(); run_seq(3'b000, 1'b0);
        for (int r = 0; r < 8; r++) begin
            do_reset();
            run_seq(NS'($urandom_range(0, 7)), r[0]);
        end

        // BRAM mux ownership, then abort from RUN on stage 1.
        do_reset();
        sel = 1'b0; en = 3'b111; go = 1'b1;
        step();
        go = 1'b0;
        step();
        addr_in[0 +: AW] = 19'h12345; wdata_in[0 +: DW] = 3'b101;
        addr_in[AW +: AW] = AW'($urandom); wdata_in[DW +: DW] = DW'($urandom);
        we_in = 3'b011;
        step();
        check("mux_addr", 32'(o_addr), 32'h12345);
        check("mux_wdata", 32'(o_wd), 32'd5);
        check("mux_we", 32'(o_we), 32'd1);
        addr_in[0 +: AW] = 19'h00abc; we_in = 3'b010;
        step();
        check("mux_other_we", 32'(o_we), 32'd0);
        check("mux_addr2", 32'(o_addr), 32'h00abc);
        done = 3'b001;
        step();
        done = '0;
        check("adv_we_dir", 32'(o_we), 32'd0);
        step();
        check("launch1_start", 32'(o_start), 32'b010);
        step();
        we_in = 3'b010;
        step();
        check("run1_we", 32'(o_we), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_we", 32'(o_we), 32'd0);
        check("abort_seq_done", 32'(o_sd), 32'd0);
        check("abort_state_out", 32'(o_st), 32'(S_RUN));
        step();
        check("abort_idle", 32'(o_st), 32'(S_IDLE));
        check("abort_no_done", 32'(o_sd), 32'd0);
        go = 1'b1;
        step();
        go = 1'b0;
        check("restart_start", 32'(o_start), 32'b001);
        check("restart_act", 32'(o_act), 32'd0);
        abort = 1'b1;
        #1;
        check("abort_launch_start", 32'(o_start), 32'd0);
        step();
        abort = 1'b0;
        check("abort_launch_busy", 32'(o_busy), 32'd0);
        go = 1'b1; abort = 1'b1;
        step();
        go = 1'b0; abort = 1'b0;
        check("go_abort_busy", 32'(o_busy), 32'd0);

        // Asynchronous reset while a write is in flight.
        do_reset();
        sel = 1'b0; en = 3'b100; go = 1'b1;
        step();
        go = 1'b0;
        step();
        we_in = 3'b100;
        step();
        check("pre_rst_we", 32'(o_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_we", 32'(o_we), 32'd0);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        check("async_rst_act", 32'(o_act), 32'd0);
        check("async_rst_state_out", 32'(o_st), 32'(S_IDLE));

        // Stage 0 never reports done.
        do_reset();
        sel = 1'b0; en = 3'b011; go = 1'b1;
        step();
        go = 1'b0;
        step();
`ifdef STAGE_WATCHDOG_EN
        for (int i = 1; i < TO; i++) begin
            step();
            check("wd_pre_err", 32'(o_err), 32'd0);
        end
        step();
        check("wd_err", 32'(o_err), 32'd1);
        check("wd_err_we", 32'(o_we), 32'd0);
        check("wd_err_busy", 32'(o_busy), 32'd1);
        step();
        check("wd_err_sticky", 32'(o_err), 32'd1);
        check("wd_err_state_out", 32'(o_st), 32'(S_ERR));
        go = 1'b1;
        step();
        go = 1'b0;
        check("wd_go_clears", 32'(o_err), 32'd0);
        check("wd_relaunch", 32'(o_start), 32'b001);
`else
        for (int i = 0; i < 20; i++) step();
        check("no_wd_err", 32'(o_err), 32'd0);
        check("no_wd_busy", 32'(o_busy), 32'd1);
        check("no_wd_state_out", 32'(o_st), 32'(S_RUN));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
